// File: rtl/counter_monitor_chk_pkg.sv
// Shared definitions for the counter monitor: event type codes and record width helper.
package counter_mon_pkg;

  localparam logic [1:0] EVT_RESET    = 2'b00;
  localparam logic [1:0] EVT_EN_RISE  = 2'b01;
  localparam logic [1:0] EVT_EN_FALL  = 2'b10;
  localparam logic [1:0] EVT_MISMATCH = 2'b11;

  // Event record layout is {timestamp, type[1:0], count}.
  function automatic int evt_rec_w(input int ts_w, input int cnt_w);
    return ts_w + 2 + cnt_w;
  endfunction

endpackage

// File: rtl/counter_monitor_chk_if.sv
// Bundle of observed-counter signals, event drain port and status flags of the counter monitor.
interface counter_monitor_chk_if #(
  parameter int CNT_W = 4,
  parameter int TS_W  = 16,
  parameter int ERR_W = 8
);
  import counter_mon_pkg::*;

  localparam int REC_W = evt_rec_w(TS_W, CNT_W);

  logic             mon_reset;
  logic             mon_enable;
  logic [CNT_W-1:0] mon_count;
  logic             evt_valid;
  logic             evt_ready;
  logic [REC_W-1:0] evt_data;
  logic             err_flag;
  logic [ERR_W-1:0] err_count;
  logic             ovf_flag;

  modport master (
    output mon_reset, mon_enable, mon_count, evt_ready,
    input  evt_valid, evt_data, err_flag, err_count, ovf_flag
  );

  modport slave (
    input  mon_reset, mon_enable, mon_count, evt_ready,
    output evt_valid, evt_data, err_flag, err_count, ovf_flag
  );

endinterface

// File: rtl/counter_monitor_chk_sync_fifo.sv
// Synchronous first-word fall-through FIFO; a push while full is accepted only alongside a pop.
module sync_fifo #(
  parameter int WIDTH = 22,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             wr_en;
  logic             rd_en;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;
  assign dout  = empty ? '0 : mem_q[rd_q[AW-1:0]];

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (wr_en) begin
      mem_d[wr_q[AW-1:0]] = din;
      wr_d = wr_q + (AW+1)'(1);
    end
    if (rd_en) begin
      rd_d = rd_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/counter_monitor_chk.sv
// Observer for a 4-bit enable/reset counter: predicts each count, flags mismatches, logs timestamped events.
module counter_monitor_chk
  import counter_mon_pkg::*;
#(
  parameter int CNT_W = 4,
  parameter int TS_W  = 16,
  parameter int DEPTH = 8,
  parameter int ERR_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  counter_monitor_chk_if.slave  bus
);

  localparam int REC_W = evt_rec_w(TS_W, CNT_W);

  logic [TS_W-1:0]  ts_q, ts_d;
  logic             mon_reset_q, mon_reset_d;
  logic             mon_enable_q, mon_enable_d;
  logic [CNT_W-1:0] mon_count_q, mon_count_d;
  logic             primed_q, primed_d;
  logic             err_flag_q, err_flag_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;
  logic             ovf_flag_q, ovf_flag_d;

  logic [CNT_W-1:0] exp_count;
  logic             mismatch;
  logic             rst_rise;
  logic             en_rise;
  logic             en_fall;
  logic             push;
  logic             pop;
  logic [1:0]       evt_type;
  logic [REC_W-1:0] push_data;
  logic [REC_W-1:0] fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;

  // Prediction always starts from the observed previous count, so a mismatch resyncs the model.
  always_comb begin
    exp_count = mon_count_q;
    if (mon_reset_q) begin
      exp_count = '0;
    end else if (mon_enable_q) begin
      exp_count = mon_count_q + CNT_W'(1);
    end
  end

  always_comb begin
    mismatch = primed_q && (bus.mon_count != exp_count);
    rst_rise = bus.mon_reset && !mon_reset_q;
    en_rise  = bus.mon_enable && !mon_enable_q;
    en_fall  = !bus.mon_enable && mon_enable_q;
    push     = !reset && (mismatch || rst_rise || en_rise || en_fall);
    pop      = !fifo_empty && bus.evt_ready;

    evt_type = EVT_EN_FALL;
    if (mismatch) begin
      evt_type = EVT_MISMATCH;
    end else if (rst_rise) begin
      evt_type = EVT_RESET;
    end else if (en_rise) begin
      evt_type = EVT_EN_RISE;
    end
    push_data = {ts_q, evt_type, bus.mon_count};
  end

  always_comb begin
    ts_d         = ts_q + TS_W'(1);
    mon_reset_d  = bus.mon_reset;
    mon_enable_d = bus.mon_enable;
    mon_count_d  = bus.mon_count;
    primed_d     = 1'b1;
    err_flag_d   = err_flag_q | mismatch;
    err_count_d  = err_count_q;
    if (mismatch && (err_count_q != '1)) begin
      err_count_d = err_count_q + ERR_W'(1);
    end
    ovf_flag_d = ovf_flag_q | (push && fifo_full && !pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ts_q         <= '0;
      mon_reset_q  <= 1'b0;
      mon_enable_q <= 1'b0;
      mon_count_q  <= '0;
      primed_q     <= 1'b0;
      err_flag_q   <= 1'b0;
      err_count_q  <= '0;
      ovf_flag_q   <= 1'b0;
    end else begin
      ts_q         <= ts_d;
      mon_reset_q  <= mon_reset_d;
      mon_enable_q <= mon_enable_d;
      mon_count_q  <= mon_count_d;
      primed_q     <= primed_d;
      err_flag_q   <= err_flag_d;
      err_count_q  <= err_count_d;
      ovf_flag_q   <= ovf_flag_d;
    end
  end

  sync_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (push_data),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.evt_valid = !fifo_empty;
  assign bus.evt_data  = fifo_dout;
  assign bus.err_flag  = err_flag_q;
  assign bus.err_count = err_count_q;
  assign bus.ovf_flag  = ovf_flag_q;

endmodule
